pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 96 +++++++++
 tb/tb_pipe_skid_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline register with an optional skid entry. Latency 1 cycle. With SKID=1 in_ready is registered and
// a second entry absorbs the cycle of backpressure; with SKID=0 in_ready follows out_ready combinationally.
module pipe_skid_reg #(
    parameter int DW   = 69,
    parameter int CW   = 11,
    parameter int SKID = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ctrl,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ctrl,
    output logic [DW-1:0] out_data,
    input  logic          flush,
    output logic [1:0]    occupancy
);

    localparam bit SKID_EN = (SKID != 0);

    logic          main_vld_q, main_vld_d;
    logic          skid_vld_q, skid_vld_d;
    logic [CW-1:0] main_ctrl_q, main_ctrl_d;
    logic [DW-1:0] main_data_q, main_data_d;
    logic [CW-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic [1:0]    occ_q, occ_d;
    logic          accept;
    logic          drain;

    assign in_ready = SKID_EN ? ~skid_vld_q : (~main_vld_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign drain    = main_vld_q & out_ready;

    always_comb begin
        main_vld_d  = main_vld_q;
        skid_vld_d  = skid_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Accepts in a flush cycle are dropped; data registers keep stale values.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (drain) begin
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q || drain) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else if (SKID_EN) begin
                skid_vld_d  = 1'b1;
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
            end
        end else if (drain) begin
            main_vld_d = 1'b0;
        end
        occ_d = {1'b0, main_vld_d} + {1'b0, skid_vld_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            occ_q       <= 2'd0;
        end else begin
            main_vld_q  <= main_vld_d;
            skid_vld_q  <= skid_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            occ_q       <= occ_d;
        end
    end

    assign out_valid = main_vld_q;
    assign out_ctrl  = main_vld_q ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed table plus random scoreboard for pipe_skid_reg in skid, single-entry and narrow configurations.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [10:0] in_ctrl = '0;
    logic [68:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;

    logic        ir0, ov0, ir1, ov1, ir2, ov2;
    logic [10:0] oc0, oc1;
    logic [68:0] od0, od1;
    logic [0:0]  oc2;
    logic [7:0]  od2;
    logic [1:0]  occ0, occ1, occ2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_skid_reg u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl),
        .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0),
        .out_data(od0), .flush(flush), .occupancy(occ0));

    pipe_skid_reg #(.SKID(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl),
        .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1),
        .out_data(od1), .flush(flush), .occupancy(occ1));

    pipe_skid_reg #(.DW(8), .CW(1), .SKID(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_ctrl(in_ctrl[0:0]),
        .in_data(in_data[7:0]), .out_valid(ov2), .out_ready(out_ready), .out_ctrl(oc2),
        .out_data(od2), .flush(flush), .occupancy(occ2));

    typedef struct {
        bit          iv;
        bit          fl;
        bit          ordy;
        logic [68:0] d;
        logic [10:0] c;
        bit          e_ir;
        bit          e_ov;
        logic [68:0] e_od;
        logic [10:0] e_oc;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vec[17];
    logic [79:0] sb0[$];
    logic [79:0] sb1[$];
    logic [79:0] sb2[$];

    task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic vec_t row(bit iv, bit fl, bit ordy, int d, int c,
                                 bit e_ir, bit e_ov, int e_od, int e_oc, int e_occ);
        vec_t r;
        r.iv = iv; r.fl = fl; r.ordy = ordy; r.d = 69'(d); r.c = 11'(c);
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = 69'(e_od); r.e_oc = 11'(e_oc); r.e_occ = 2'(e_occ);
        return r;
    endfunction

    initial begin
        //            iv fl or  d   c  ir ov od oc occ
        vec[0]  = row(1, 0, 1,  1,  1, 1, 1,  1, 1, 1);  // streaming
        vec[1]  = row(1, 0, 1,  2,  2, 1, 1,  2, 2, 1);
        vec[2]  = row(1, 0, 1,  3,  3, 1, 1,  3, 3, 1);
        vec[3]  = row(0, 0, 1,  0,  0, 1, 0,  3, 0, 0);
        vec[4]  = row(1, 0, 0, 10,  5, 1, 1, 10, 5, 1);  // backpressure
        vec[5]  = row(1, 0, 0, 11,  6, 0, 1, 10, 5, 2);
        vec[6]  = row(1, 0, 0, 12,  7, 0, 1, 10, 5, 2);
        vec[7]  = row(0, 0, 1,  0,  0, 1, 1, 11, 6, 1);
        vec[8]  = row(0, 0, 1,  0,  0, 1, 0, 11, 0, 0);
        vec[9]  = row(1, 0, 0, 20,  7, 1, 1, 20, 7, 1);  // flush with both entries held
        vec[10] = row(1, 0, 0, 21,  8, 0, 1, 20, 7, 2);
        vec[11] = row(1, 1, 0, 22, 10, 1, 0, 20, 0, 0);
        vec[12] = row(1, 0, 0, 30,  9, 1, 1, 30, 9, 1);  // flush with real accept and drain
        vec[13] = row(1, 1, 1, 31, 12, 1, 0, 30, 0, 0);
        vec[14] = row(0, 0, 1,  0,  0, 1, 0, 30, 0, 0);
        vec[15] = row(1, 0, 0, 40,  3, 1, 1, 40, 3, 1);  // fill before async reset
        vec[16] = row(1, 0, 0, 41,  4, 0, 1, 40, 3, 2);

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ov", 80'(ov0), 80'(0));
        chk("rst_oc", 80'(oc0), 80'(0));
        chk("rst_od", 80'(od0), 80'(0));
        chk("rst_occ", 80'(occ0), 80'(0));
        chk("rst_ir_skid", 80'(ir0), 80'(1));
        chk("rst_ir_noskid", 80'(ir1), 80'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = vec[i].iv; flush = vec[i].fl; out_ready = vec[i].ordy;
            in_data = vec[i].d; in_ctrl = vec[i].c;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ir", i), 80'(ir0), 80'(vec[i].e_ir));
            chk($sformatf("v%0d_ov", i), 80'(ov0), 80'(vec[i].e_ov));
            chk($sformatf("v%0d_od", i), 80'(od0), 80'(vec[i].e_od));
            chk($sformatf("v%0d_oc", i), 80'(oc0), 80'(vec[i].e_oc));
            chk($sformatf("v%0d_occ", i), 80'(occ0), 80'(vec[i].e_occ));
        end

        // Asynchronous reset between edges with two entries held.
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", 80'(ov0), 80'(0));
        chk("arst_oc", 80'(oc0), 80'(0));
        chk("arst_od", 80'(od0), 80'(0));
        chk("arst_occ", 80'(occ0), 80'(0));
        chk("arst_ir", 80'(ir0), 80'(1));
        #1 rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 69'd50; in_ctrl = 11'd2;
        @(posedge clk);
        #1;
        chk("post_rst_ov", 80'(ov0), 80'(1));
        chk("post_rst_od", 80'(od0), 80'(50));
        chk("post_rst_occ", 80'(occ0), 80'(1));

        // Single-entry mode: combinational in_ready.
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1 rst_n = 1'b1;
        in_valid = 1'b1; in_data = 69'd60; in_ctrl = 11'd1; out_ready = 1'b0;
        #1 chk("s0_ir_empty", 80'(ir1), 80'(1));
        @(posedge clk);
        #1;
        chk("s0_ov", 80'(ov1), 80'(1));
        chk("s0_od", 80'(od1), 80'(60));
        chk("s0_ir_full", 80'(ir1), 80'(0));
        @(negedge clk);
        in_data = 69'd61; in_ctrl = 11'd2; out_ready = 1'b1;
        #1 chk("s0_ir_release", 80'(ir1), 80'(1));
        @(posedge clk);
        #1;
        chk("s0_pass_od", 80'(od1), 80'(61));
        chk("s0_pass_oc", 80'(oc1), 80'(2));
        chk("s0_pass_occ", 80'(occ1), 80'(1));
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("s0_empty_ov", 80'(ov1), 80'(0));
        chk("s0_empty_occ", 80'(occ1), 80'(0));

        // Random traffic with per-instance scoreboards.
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            chk("rnd_occ0", 80'(occ0), 80'(sb0.size()));
            chk("rnd_occ1", 80'(occ1), 80'(sb1.size()));
            chk("rnd_occ2", 80'(occ2), 80'(sb2.size()));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_data   = {$urandom, $urandom, $urandom};
            in_ctrl   = 11'($urandom);
            #1;
            if (ov0 && out_ready) begin
                if (sb0.size() == 0) chk("rnd_dup0", 80'(1), 80'(0));
                else chk("rnd_order0", {oc0, od0}, sb0.pop_front());
            end
            if (!ov0) chk("rnd_ctrl0", 80'(oc0), 80'(0));
            if (in_valid && ir0) sb0.push_back({in_ctrl, in_data});
            if (flush) sb0.delete();

            if (ov1 && out_ready) begin
                if (sb1.size() == 0) chk("rnd_dup1", 80'(1), 80'(0));
                else chk("rnd_order1", {oc1, od1}, sb1.pop_front());
            end
            if (!ov1) chk("rnd_ctrl1", 80'(oc1), 80'(0));
            if (in_valid && ir1) sb1.push_back({in_ctrl, in_data});
            if (flush) sb1.delete();

            if (ov2 && out_ready) begin
                if (sb2.size() == 0) chk("rnd_dup2", 80'(1), 80'(0));
                else chk("rnd_order2", 80'({oc2, od2}), sb2.pop_front());
            end
            if (!ov2) chk("rnd_ctrl2", 80'(oc2), 80'(0));
            if (in_valid && ir2) sb2.push_back(80'({in_ctrl[0], in_data[7:0]}));
            if (flush) sb2.delete();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
